key_debounce_loader: RTL and testbench
======================================

Name: key_debounce_loader

Overview:
Upstream front-end for the switch-capture/hex-display stage. It conditions a raw active-low pushbutton, then emits one load strobe per debounced press. On that strobe it presents a registered snapshot of the switch bank on d_out, which feeds the D input of the capture stage. Bounce, glitches and held keys produce no spurious loads.

Parameters:
WIDTH, 8, width of sw and d_out
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change; legal range >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
resetnot  input  1  synchronous active-low reset
key_n  input  1  raw pushbutton, 0 = pressed, asynchronous to clk
sw  input  WIDTH  raw switch bank
d_out  output  WIDTH  snapshot of sw taken at accepted press, to capture stage D
load_pulse  output  1  one-cycle strobe, high in the cycle d_out becomes valid
key_clean  output  1  debounced level, 1 = pressed

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is sampled only on a rising clk edge with resetnot = 0; there is no asynchronous path.
- Reset values:
  - state = RELEASED, cnt = 0.
  - Synchroniser flops s1 = s2 = 1 (released).
  - d_out = 0, load_pulse = 0, key_clean = 0.
- Synchroniser:
  - key_n passes through two flops (s1 then s2).
  - The FSM uses s2 only.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - It never exceeds DEBOUNCE_CYCLES.
- FSM states and transitions, evaluated each edge:
  - RELEASED: if s2 = 0, go to PRESS_WAIT with cnt = 1. Otherwise stay, cnt = 0.
  - PRESS_WAIT:
    - If s2 = 1, go to RELEASED with cnt = 0 (bounce rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES, go to PRESSED, cnt = 0, d_out <= sw, load_pulse <= 1.
    - Else cnt <= cnt + 1.
  - PRESSED: if s2 = 1, go to RELEASE_WAIT with cnt = 1. Otherwise stay.
  - RELEASE_WAIT:
    - If s2 = 0, go to PRESSED with cnt = 0 (no new pulse).
    - Else if cnt == DEBOUNCE_CYCLES, go to RELEASED with cnt = 0.
    - Else cnt <= cnt + 1.
- Outputs:
  - load_pulse is registered. It is 1 for exactly one cycle, following the PRESS_WAIT to PRESSED edge, and 0 at all other times.
  - key_clean is registered. It is 1 while state is PRESSED or RELEASE_WAIT, and 0 otherwise.
  - d_out holds its value between presses and changes only together with load_pulse.
- Latency:
  - Let edge E0 be the first edge that samples key_n = 0, with key_n held low thereafter.
  - load_pulse is high in the cycle after edge E0 + DEBOUNCE_CYCLES + 2.
- sw is not synchronised. The captured value is sw as sampled at the accepting edge; any earlier changes during PRESS_WAIT are ignored.
- Release never generates a pulse. Holding the key generates exactly one pulse.
- Reset mid-operation:
  - Any state returns to RELEASED and d_out clears.
  - If key_n is still low after reset, a full debounce runs again and one new pulse is issued.
- Reset has priority over all other events on the same edge.

Optional Feature:
PRESS_COUNT_EN
- When defined:
  - Adds output press_count [7:0], reset to 0.
  - It increments on every cycle load_pulse is 1 and wraps from 255 to 0.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: resetnot = 0 for 2 edges, key_n = 1, sw = 8'hA5 -> d_out = 0, load_pulse = 0, key_clean = 0 for 50 cycles.
- Clean press, DEBOUNCE_CYCLES = 4, sw = 8'h44, key_n low from E0 -> one load_pulse in the cycle after E0+6; d_out = 8'h44 from then; key_clean = 1.
- Bounce, DEBOUNCE_CYCLES = 4: key_n low 3 cycles, high 1, low 3, high -> no load_pulse, d_out unchanged, key_clean stays 0.
- Hold and release glitch: press accepted with sw = 8'h88; key_n high 2 cycles, then low 20, then high 10 -> exactly one pulse total; key_clean = 1 through the glitch and 0 after release completes.
- sw changes during debounce: sw = 8'h01, then 8'hAA one edge before acceptance -> d_out = 8'hAA.
- Reset mid-hold: press accepted, d_out = 8'hBB; resetnot = 0 one edge while key_n stays low -> d_out = 0, then a second pulse DEBOUNCE_CYCLES+3 edges after reset release. With PRESS_COUNT_EN defined, press_count = 1 after the second pulse.

Source files
------------

// File: rtl/key_debounce_loader.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM, one load strobe per accepted press
// with a registered switch snapshot. Define PRESS_COUNT_EN to add an 8-bit press counter output.
module key_debounce_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             resetnot,
    input  logic             key_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] d_out,
    output logic             load_pulse,
    output logic             key_clean,
    output logic [1:0]       state_dbg
`ifdef PRESS_COUNT_EN
    ,
    output logic [7:0]       press_count
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          s1, s2;
    logic          accept;
    logic          key_clean_nxt;

    // Handshake: none; load_pulse is a one-cycle strobe qualifying d_out, no back-pressure.
    always_ff @(posedge clk) begin
        if (!resetnot) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            state      <= RELEASED;
            cnt        <= '0;
            d_out      <= '0;
            load_pulse <= 1'b0;
            key_clean  <= 1'b0;
        end else begin
            s1         <= key_n;
            s2         <= s1;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            load_pulse <= accept;
            key_clean  <= key_clean_nxt;
            if (accept) begin
                d_out <= sw;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            RELEASED: begin
                if (!s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                // A low sample returns to PRESSED silently: a release glitch is not a new press.
                if (!s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        key_clean_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

    assign state_dbg = state;

`ifdef PRESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!resetnot) begin
            press_count <= 8'd0;
        end else if (load_pulse) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce_loader.sv
// Directed bench for key_debounce_loader (DEBOUNCE_CYCLES = 4): scoreboard of expected snapshots,
// popped whenever load_pulse is seen.
module tb_key_debounce_loader;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         resetnot;
    logic         key_n;
    logic [W-1:0] sw;
    logic [W-1:0] d_out;
    logic         load_pulse;
    logic         key_clean;
    logic [1:0]   state_dbg;
`ifdef PRESS_COUNT_EN
    logic [7:0]   press_count;
`endif

    int errors = 0;
    int checks = 0;
    int pulse_count = 0;
    logic [W-1:0] exp_q[$];

    key_debounce_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .resetnot   (resetnot),
        .key_n      (key_n),
        .sw         (sw),
        .d_out      (d_out),
        .load_pulse (load_pulse),
        .key_clean  (key_clean),
        .state_dbg  (state_dbg)
`ifdef PRESS_COUNT_EN
        ,
        .press_count(press_count)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // driver: advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every strobe must match the oldest expected snapshot
    always @(negedge clk) begin
        if (load_pulse === 1'b1) begin
            pulse_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(load_pulse), 32'd0);
            end else begin
                check("pulse_d_out", 32'(d_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        resetnot = 1'b0;
        key_n    = 1'b1;
        sw       = 8'hA5;

        // reset then idle
        tick(2);
        check("reset_d_out", 32'(d_out), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        resetnot = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_d_out", 32'(d_out), 32'd0);
            check("idle_load", 32'(load_pulse), 32'd0);
            check("idle_clean", 32'(key_clean), 32'd0);
        end

        // clean press: pulse in the cycle after E0+D+2
        sw    = 8'h44;
        key_n = 1'b0;
        exp_q.push_back(8'h44);
        tick(D + 2);
        check("clean_pre_load", 32'(load_pulse), 32'd0);
        check("clean_pre_clean", 32'(key_clean), 32'd0);
        tick(1);
        check("clean_load", 32'(load_pulse), 32'd1);
        check("clean_d_out", 32'(d_out), 32'h44);
        check("clean_clean", 32'(key_clean), 32'd1);
        tick(1);
        check("clean_post_load", 32'(load_pulse), 32'd0);
        check("clean_hold_clean", 32'(key_clean), 32'd1);
        tick(10);
        check("clean_hold_pulses", 32'(pulse_count), 32'd1);
        key_n = 1'b1;
        tick(D + 10);
        check("clean_release", 32'(key_clean), 32'd0);

        // bounce: never D+1 consecutive low samples
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(1);
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(20);
        check("bounce_pulses", 32'(pulse_count), 32'd1);
        check("bounce_d_out", 32'(d_out), 32'h44);
        check("bounce_clean", 32'(key_clean), 32'd0);

        // hold with release glitch
        sw    = 8'h88;
        key_n = 1'b0;
        exp_q.push_back(8'h88);
        tick(10);
        check("hold_d_out", 32'(d_out), 32'h88);
        key_n = 1'b1; tick(2);
        key_n = 1'b0;
        check("glitch_clean_a", 32'(key_clean), 32'd1);
        tick(3);
        check("glitch_clean_b", 32'(key_clean), 32'd1);
        tick(17);
        check("glitch_pulses", 32'(pulse_count), 32'd2);
        key_n = 1'b1;
        tick(D + 2);
        check("release_wait_clean", 32'(key_clean), 32'd1);
        tick(4);
        check("release_done_clean", 32'(key_clean), 32'd0);
        check("release_pulses", 32'(pulse_count), 32'd2);

        // switch change just before the accepting edge
        sw    = 8'h01;
        key_n = 1'b0;
        exp_q.push_back(8'hAA);
        tick(D + 2);
        sw = 8'hAA;
        tick(1);
        check("swchg_load", 32'(load_pulse), 32'd1);
        check("swchg_d_out", 32'(d_out), 32'hAA);
        key_n = 1'b1;
        tick(D + 10);
        check("swchg_release", 32'(key_clean), 32'd0);

        // reset mid-hold
        sw    = 8'hBB;
        key_n = 1'b0;
        exp_q.push_back(8'hBB);
        tick(10);
        check("rst_pre_d_out", 32'(d_out), 32'hBB);
        resetnot = 1'b0;
        tick(1);
        resetnot = 1'b1;
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_clean", 32'(key_clean), 32'd0);
        check("rst_load", 32'(load_pulse), 32'd0);
        exp_q.push_back(8'hBB);
        tick(D + 2);
        check("rst_pre_load", 32'(load_pulse), 32'd0);
        tick(1);
        check("rst_load2", 32'(load_pulse), 32'd1);
        check("rst_d_out2", 32'(d_out), 32'hBB);
        tick(2);
        check("rst_clean2", 32'(key_clean), 32'd1);
`ifdef PRESS_COUNT_EN
        check("press_count", 32'(press_count), 32'd1);
`endif
        key_n = 1'b1;
        tick(D + 10);

        check("total_pulses", 32'(pulse_count), 32'd5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
